// File: rtl/ldpc_encoder.sv
// Systematic (10,5) LDPC encoder: serial message in, signed channel-evidence symbols out.
// Optional error injection on one emitted symbol when LDPC_ENC_ERRINJ_EN is defined.
module ldpc_encoder #(
    parameter int LLR_W   = 32,
    parameter int LLR_MAG = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             msg_bit,
    input  logic             msg_valid,
    output logic             msg_ready,
    output logic [LLR_W-1:0] cw_llr,
    output logic             cw_valid,
    input  logic             cw_ready,
    output logic             cw_last
`ifdef LDPC_ENC_ERRINJ_EN
    ,
    input  logic             err_en,
    input  logic [3:0]       err_pos
`endif
);

    localparam int unsigned K     = 5;
    localparam int unsigned N     = 10;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned IDX_W = 4;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(K - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    localparam logic [LLR_W-1:0] LLR_POS = LLR_W'(LLR_MAG);
    localparam logic [LLR_W-1:0] LLR_NEG = LLR_W'(-LLR_MAG);

    // Bit 0 maps to positive evidence, bit 1 to negative.
    function automatic logic [LLR_W-1:0] llr_of(input logic c);
        return c ? LLR_NEG : LLR_POS;
    endfunction

    logic [0:0]       state;
    logic [0:0]       next_state;
    logic [CNT_W-1:0] count;
    logic [K-1:0]     parity;
    logic [K-1:0]     sys_bits;
    logic [N-1:0]     cw_bits;
    logic [IDX_W-1:0] sym_idx;

    logic             msg_fire;
    logic             cw_fire;
    logic             load_done;
    logic             emit_done;
    logic [K-1:0]     bit_mask;
    logic [K-1:0]     parity_next;
    logic [K-1:0]     sys_next;
    logic [N-1:0]     flip_mask;
    logic [N-1:0]     cw_next;
    logic [IDX_W-1:0] idx_next;

    // Handshakes, parity accumulation and next-state decode.
    always_comb begin
        next_state  = state;
        msg_fire    = (state == ST_LOAD) && msg_valid;
        cw_fire     = (state == ST_EMIT) && cw_valid && cw_ready;
        load_done   = msg_fire && (count == LAST_CNT);
        emit_done   = cw_fire && (sym_idx == LAST_IDX);
        idx_next    = sym_idx + IDX_W'(1);
        bit_mask    = 5'b10001;
        flip_mask   = '0;

        case (count)
            3'd0:    bit_mask = 5'b00011;
            3'd1:    bit_mask = 5'b00110;
            3'd2:    bit_mask = 5'b01100;
            3'd3:    bit_mask = 5'b11000;
            default: bit_mask = 5'b10001;
        endcase

        parity_next = msg_bit ? (parity ^ bit_mask) : parity;
        sys_next    = msg_bit ? (sys_bits | (K'(1) << count)) : sys_bits;

`ifdef LDPC_ENC_ERRINJ_EN
        if (err_en && (err_pos <= LAST_IDX)) begin
            flip_mask = N'(1) << err_pos;
        end
`endif

        // Codeword frozen on the final message bit, with any injected flip folded in.
        cw_next = {parity_next, sys_next} ^ flip_mask;

        case (state)
            ST_LOAD: if (load_done) next_state = ST_EMIT;
            ST_EMIT: if (emit_done) next_state = ST_LOAD;
            default: next_state = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_LOAD;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            msg_ready <= 1'b1;
            count     <= '0;
            parity    <= '0;
            sys_bits  <= '0;
            cw_bits   <= '0;
            sym_idx   <= '0;
            cw_valid  <= 1'b0;
            cw_llr    <= '0;
            cw_last   <= 1'b0;
        end else begin
            msg_ready <= (next_state == ST_LOAD);

            if (load_done) begin
                cw_bits  <= cw_next;
                cw_valid <= 1'b1;
                cw_llr   <= llr_of(cw_next[0]);
                cw_last  <= 1'b0;
                sym_idx  <= '0;
                count    <= '0;
                parity   <= '0;
                sys_bits <= '0;
            end else if (msg_fire) begin
                count    <= count + CNT_W'(1);
                parity   <= parity_next;
                sys_bits <= sys_next;
            end

            // Outputs advance only on an accepted symbol, so they hold through back-pressure.
            if (emit_done) begin
                cw_valid <= 1'b0;
                cw_llr   <= '0;
                cw_last  <= 1'b0;
                sym_idx  <= '0;
            end else if (cw_fire) begin
                sym_idx  <= idx_next;
                cw_llr   <= llr_of(cw_bits[idx_next]);
                cw_last  <= (idx_next == LAST_IDX);
            end
        end
    end

endmodule
